// File: rtl/buffer_pkg.sv
// Shared defaults for the sum-buffer read path: data width, FIFO read latency, counter width.
package buffer_pkg;

  localparam int unsigned NDef     = 32;
  localparam int unsigned RdLatDef = 1;
  localparam int unsigned CntWDef  = 16;

  // Two extra entries beyond the read latency keep one word per cycle flowing.
  function automatic int unsigned depth_for(input int unsigned rd_lat);
    return rd_lat + 2;
  endfunction

  localparam int unsigned DepthDef = depth_for(RdLatDef);

endpackage

// File: rtl/stream_skid_buf.sv
// Small register FIFO whose head entry is the output register; entry 0 is always the head.
module stream_skid_buf
  import buffer_pkg::*;
#(
  parameter int unsigned N     = NDef,
  parameter int unsigned DEPTH = DepthDef
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_i,
  input  logic [N-1:0]                 din_i,
  input  logic                         rd_i,
  output logic [N-1:0]                 dout_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [N-1:0]    mem_q [DEPTH];
  logic [N-1:0]    mem_d [DEPTH];
  logic [OccW-1:0] occ_q, occ_d, occ_pop;
  logic            valid_q, valid_d;
  logic            pop;

  always_comb begin
    mem_d   = mem_q;
    pop     = rd_i && (occ_q != '0);
    occ_pop = pop ? occ_q - OccW'(1) : occ_q;
    if (pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i + 1];
      end
    end
    // New word lands just behind whatever survives this cycle's pop.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_i && (OccW'(i) == occ_pop)) begin
        mem_d[i] = din_i;
      end
    end
    occ_d   = occ_pop + OccW'(wr_i);
    valid_d = (occ_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q   <= '{default: '0};
      occ_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign dout_o  = mem_q[0];
  assign valid_o = valid_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/buffer_drain.sv
// Drains the sum-buffer FIFO onto a valid/ready stream; credits cover words still in flight.
module buffer_drain
  import buffer_pkg::*;
#(
  parameter int unsigned N      = NDef,
  parameter int unsigned RD_LAT = RdLatDef,
  parameter int unsigned CNT_W  = CntWDef
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [N-1:0]     fifo_q_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rdreq_o,
  output logic [N-1:0]     out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam int unsigned DEPTH = depth_for(RD_LAT);
  localparam int unsigned OccW  = $clog2(DEPTH + 1);

  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [OccW-1:0]   occ, inflight;
  logic [OccW:0]     used;
  logic              credit_ok, land, pop;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OccW'(pipe_q[i]);
    end
    used      = {1'b0, inflight} + {1'b0, occ};
    credit_ok = (used < (OccW + 1)'(DEPTH));
  end

  assign fifo_rdreq_o = enable_i & ~fifo_empty_i & ~rst_i & credit_ok;

  // Tag each request; the oldest stage coincides with valid fifo_q.
  assign pipe_d = (pipe_q << 1) | RD_LAT'(fifo_rdreq_o);
  assign land   = pipe_q[RD_LAT-1];
  assign pop    = out_valid_o & out_ready_i;

  assign word_cnt_d = pop ? word_cnt_q + CNT_W'(1) : word_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      pipe_q     <= pipe_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  stream_skid_buf #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_store (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_i    (land),
    .din_i   (fifo_q_i),
    .rd_i    (pop),
    .dout_o  (out_data_o),
    .valid_o (out_valid_o),
    .occ_o   (occ)
  );

  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_buffer_drain.sv
// Bench for buffer_drain: behavioural FIFO feeding the DUT, expected-word queue, output monitor.
module tb_buffer_drain;

  localparam int unsigned N     = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, enable, fifo_empty, fifo_rdreq, out_valid, out_ready;
  logic [N-1:0]     fifo_q, out_data;
  logic [CNT_W-1:0] word_cnt;
  logic             force_empty;

  logic [N-1:0] fmem [16384];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  logic [N-1:0] exp_q [$];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  buffer_drain #(
    .N      (N),
    .RD_LAT (1),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .fifo_q_i     (fifo_q),
    .fifo_empty_i (fifo_empty),
    .fifo_rdreq_o (fifo_rdreq),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .word_cnt_o   (word_cnt)
  );

  // Normal-mode FIFO: data one cycle after rdreq, empty reflects reads up to the last edge.
  assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

  initial fifo_q = '0;

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rdreq) begin
      fifo_q <= fmem[rd_ptr % 16384];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor: every transfer must match the oldest expected word; no read while empty.
  always @(negedge clk) begin
    logic [N-1:0] e;
    if (fifo_rdreq) begin
      vectors++;
      if (fifo_empty !== 1'b0) begin
        miscompares++;
        $display("FAIL underflow: rdreq=1 with fifo_empty=%b, required empty=0", fifo_empty);
      end
    end
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stream_data: got 0x%0h, required no transfer", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          miscompares++;
          $display("FAIL stream_data: got 0x%0h, required 0x%0h", out_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] d);
    fmem[wr_ptr % 16384] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  initial begin
    int er [6] = '{1, 1, 1, 0, 0, 0};
    int ev [6] = '{0, 0, 1, 1, 1, 0};
    int rq, n, ones, gaps, first, last, cyc;
    logic vv [12];
    logic saw_wrap;
    logic [CNT_W-1:0] prev_cnt;

    rst = 1'b1; enable = 1'b1; out_ready = 1'b0; force_empty = 1'b0;
    // Non-empty FIFO during reset; the word is discarded by the shared reset.
    fmem[0] = 32'h0000_0BAD;
    wr_ptr  = 1;

    // 1: reset
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_rdreq", 32'(fifo_rdreq), 0);
      check("reset_valid", 32'(out_valid), 0);
      check("reset_cnt", 32'(word_cnt), 0);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // 2: three-word stream, cycle-exact
    push(32'h5); push(32'h7); push(32'h9);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("stream_rdreq", 32'(fifo_rdreq), 32'(er[c]));
      check("stream_valid", 32'(out_valid), 32'(ev[c]));
      if (c == 5) check("stream_cnt", 32'(word_cnt), 3);
      tick();
    end

    // 3: back-pressure then release
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(32'hA00 + 32'(i));
    rq = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (fifo_rdreq) rq++;
      tick();
    end
    @(negedge clk);
    check("bp_rdreq_count", 32'(rq), 3);
    check("bp_rdreq_hold", 32'(fifo_rdreq), 0);
    check("bp_valid", 32'(out_valid), 1);
    check("bp_head", out_data, 32'hA00);
    tick();
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      tick();
    end
    check("bp_rate", 32'(n), 10);
    check("bp_drained", 32'(exp_q.size()), 0);
    tick(); tick();

    // 4: one-cycle empty pulse mid-stream
    for (int i = 0; i < 6; i++) push(32'hB00 + 32'(i));
    for (int c = 0; c < 12; c++) begin
      force_empty = (c == 2);
      @(negedge clk);
      if (c == 2) check("empty_pulse_rdreq", 32'(fifo_rdreq), 0);
      vv[c] = out_valid;
      tick();
    end
    force_empty = 1'b0;
    ones = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      if (vv[c]) begin
        ones++;
        if (first < 0) first = c;
        last = c;
      end
    end
    gaps = (last - first + 1) - ones;
    check("empty_pulse_words", 32'(ones), 6);
    check("empty_pulse_gap", 32'(gaps), 1);

    // 5: reset with two stored words and one in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'hC00 + 32'(i));
    tick(); tick(); tick();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_rdreq", 32'(fifo_rdreq), 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_valid", 32'(out_valid), 0);
      if (c == 0) begin
        check("midrst_cnt", 32'(word_cnt), 0);
        check("midrst_data", out_data, 0);
      end
      tick();
    end

    // 6a: counter wrap with 17 transfers
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(32'hD00 + 32'(i));
    saw_wrap = 1'b0;
    prev_cnt = word_cnt;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (prev_cnt == 4'd15 && word_cnt == 4'd0) saw_wrap = 1'b1;
      prev_cnt = word_cnt;
      tick();
    end
    check("wrap_seen", 32'(saw_wrap), 1);
    check("wrap_cnt", 32'(word_cnt), 1);

    // 6b: random ready / empty over 10k words
    for (int i = 0; i < 10000; i++) push(32'h1000_0000 + 32'(i));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 60000) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 4) == 0);
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    force_empty = 1'b0;
    check("random_drained", 32'(exp_q.size()), 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
